// File: rtl/nios_pio_irq_pkg.sv
// Shared constants for the NIOS parallel I/O peripheral: register map and bus width.
package nios_pio_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd7;
endpackage

// File: rtl/nios_pio_irq_if.sv
// Avalon-MM slave bus bundle for the PIO register file.
interface nios_pio_irq_if;
    import nios_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/nios_pio_irq_debounce.sv
// One input channel: synchroniser, stability counter, and rise/fall pulses that
// coincide with the edge at which the debounced value changes.
module nios_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic db,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   upd;

    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], din};
    end

    assign s = sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign upd = (s != db);
        end else begin : g_cnt
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CNT_W-1:0] cnt;

            // Terminal count is WINDOW-1 so the update lands exactly WINDOW cycles after s changes.
            assign upd = (s != db) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk) begin
                if (reset)              cnt <= '0;
                else if (s == db || upd) cnt <= '0;
                else                    cnt <= cnt + 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)    db <= 1'b0;
        else if (upd) db <= s;
    end

    assign rise = upd &  s;
    assign fall = upd & ~s;
endmodule

// File: rtl/nios_pio_irq.sv
// Parametrised Avalon-MM PIO: debounced inputs with edge capture and masked irq,
// outputs with atomic set/clear.
module nios_pio_irq
    import nios_pio_pkg::*;
#(
    parameter int IN_WIDTH        = 2,
    parameter int OUT_WIDTH       = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    nios_pio_irq_if.slave        bus,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out
);
    logic [IN_WIDTH-1:0]  db, rise, fall, ev;
    logic [OUT_WIDTH-1:0] data_out;
    logic [IN_WIDTH-1:0]  irq_mask, edge_cap, rise_en, fall_en;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [IN_WIDTH-1:0]  wd_in;
    logic [DATA_W-1:0]    rd_mux;

    genvar i;
    generate
        for (i = 0; i < IN_WIDTH; i++) begin : g_in
            nios_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .din   (pio_in[i]),
                .db    (db[i]),
                .rise  (rise[i]),
                .fall  (fall[i])
            );
        end
    endgenerate

    assign wd_out = bus.writedata[OUT_WIDTH-1:0];
    assign wd_in  = bus.writedata[IN_WIDTH-1:0];
    assign ev     = (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            edge_cap <= '0;
        end else begin
            // Event OR'd after the clear so a same-cycle edge survives the W1C.
            if (bus.write && bus.address == ADDR_EDGE_CAP) edge_cap <= (edge_cap & ~wd_in) | ev;
            else                                           edge_cap <= edge_cap | ev;
            if (bus.write) begin
                case (bus.address)
                    ADDR_DATA_OUT: data_out <= wd_out;
                    ADDR_IRQ_MASK: irq_mask <= wd_in;
                    ADDR_RISE_EN:  rise_en  <= wd_in;
                    ADDR_FALL_EN:  fall_en  <= wd_in;
                    ADDR_OUT_SET:  data_out <= data_out | wd_out;
                    ADDR_OUT_CLR:  data_out <= data_out & ~wd_out;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA_IN:  rd_mux = DATA_W'(db);
            ADDR_DATA_OUT: rd_mux = DATA_W'(data_out);
            ADDR_IRQ_MASK: rd_mux = DATA_W'(irq_mask);
            ADDR_EDGE_CAP: rd_mux = DATA_W'(edge_cap);
            ADDR_RISE_EN:  rd_mux = DATA_W'(rise_en);
            ADDR_FALL_EN:  rd_mux = DATA_W'(fall_en);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)         bus.readdata <= '0;
        else if (bus.read) bus.readdata <= rd_mux;
        else               bus.readdata <= '0;
    end

    assign irq     = |(edge_cap & irq_mask);
    assign pio_out = data_out;
endmodule

// File: tb/tb_nios_pio_irq.sv
// Directed bench for nios_pio_irq: register access, debounce timing, edge capture,
// set-wins collision and mid-operation reset.
module tb_nios_pio_irq;
    import nios_pio_pkg::*;

    localparam int IW = 2;
    localparam int OW = 10;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          irq;
    logic [IW-1:0] pio_in;
    logic [OW-1:0] pio_out;
    logic [31:0]   rd;
    int            n_chk = 0;
    int            n_err = 0;

    nios_pio_irq_if bus();

    nios_pio_irq #(
        .IN_WIDTH        (IW),
        .OUT_WIDTH       (OW),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq     (irq),
        .pio_in  (pio_in),
        .pio_out (pio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a; bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    initial begin
        reset = 1'b1; pio_in = '0;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        tick(3);
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_pio_out", 32'(pio_out), 32'd0);
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), rd);
            chk($sformatf("rst_rd%0d", a), rd, 32'd0);
        end

        // Outputs and atomic set/clear
        bus_wr(ADDR_DATA_OUT, 32'h3FF);
        bus_wr(ADDR_OUT_CLR, 32'h00F);
        bus_wr(ADDR_OUT_SET, 32'h001);
        chk("pio_out_setclr", 32'(pio_out), 32'h3F1);
        bus_rd(ADDR_DATA_OUT, rd);
        chk("rd_data_out", rd, 32'h3F1);
        bus_wr(ADDR_DATA_OUT, 32'hFFFF_FFFF);
        bus_rd(ADDR_DATA_OUT, rd);
        chk("rd_data_out_trunc", rd, 32'h3FF);
        tick();
        chk("rd_idle_zero", bus.readdata, 32'd0);
        bus_rd(ADDR_OUT_SET, rd);
        chk("rd_out_set_zero", rd, 32'd0);

        // Read and write together return the pre-write value
        bus.address = ADDR_DATA_OUT; bus.writedata = 32'h0AA; bus.read = 1'b1; bus.write = 1'b1;
        tick();
        bus.read = 1'b0; bus.write = 1'b0;
        chk("rdwr_prewrite", bus.readdata, 32'h3FF);
        chk("rdwr_pio_out", 32'(pio_out), 32'h0AA);

        // Glitch shorter than the window is rejected
        bus_wr(ADDR_RISE_EN, 32'h1);
        bus_wr(ADDR_IRQ_MASK, 32'h1);
        pio_in[0] = 1'b1;
        tick(10);
        pio_in[0] = 1'b0;
        tick(30);
        bus_rd(ADDR_DATA_IN, rd);
        chk("glitch_data_in", rd, 32'd0);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("glitch_edge_cap", rd, 32'd0);

        // Stable rise: DATA_IN/EDGE_CAP update exactly 18 edges after the change
        bus.address = ADDR_DATA_IN; bus.read = 1'b1;
        pio_in[0] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 17) chk("rise_irq_early", {31'd0, irq}, 32'd0);
            if (k == 18) begin
                chk("rise_irq_on_time", {31'd0, irq}, 32'd1);
                chk("rise_din_before", bus.readdata, 32'd0);
            end
            if (k == 19) chk("rise_din_after", bus.readdata, 32'd1);
        end
        bus.read = 1'b0;
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("rise_edge_cap", rd, 32'h1);

        // Fall with FALL_EN clear leaves EDGE_CAP alone
        pio_in[0] = 1'b0;
        tick(25);
        bus_rd(ADDR_DATA_IN, rd);
        chk("fall_data_in", rd, 32'd0);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("fall_edge_cap", rd, 32'h1);
        chk("fall_irq_held", {31'd0, irq}, 32'd1);

        // W1C drops irq in the cycle after the write
        bus_wr(ADDR_EDGE_CAP, 32'h1);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("w1c_edge_cap", rd, 32'd0);

        // Set wins over a same-cycle W1C on bit 1
        bus_wr(ADDR_FALL_EN, 32'h2);
        pio_in[1] = 1'b1;
        tick(25);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("b1_rise_not_enabled", rd, 32'd0);
        pio_in[1] = 1'b0;
        tick(17);
        bus_wr(ADDR_EDGE_CAP, 32'h2);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("set_wins", rd, 32'h2);
        bus_wr(ADDR_EDGE_CAP, 32'h2);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("w1c_bit1", rd, 32'd0);

        // Reset in the middle of a debounce count
        bus_wr(ADDR_DATA_OUT, 32'h155);
        bus_wr(ADDR_RISE_EN, 32'h3);
        pio_in = 2'b11;
        tick(25);
        bus_wr(ADDR_IRQ_MASK, 32'h3);
        bus_wr(ADDR_FALL_EN, 32'h3);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("pre_rst_edge_cap", rd, 32'h3);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        pio_in = 2'b00;
        tick(6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_pio_out", 32'(pio_out), 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 6; a++) begin
            bus_rd(3'(a), rd);
            chk($sformatf("mid_rst_rd%0d", a), rd, 32'd0);
        end
        tick(30);
        bus_rd(ADDR_EDGE_CAP, rd);
        chk("mid_rst_no_edge", rd, 32'd0);
        bus_rd(ADDR_DATA_IN, rd);
        chk("mid_rst_data_in", rd, 32'd0);
        chk("mid_rst_irq_late", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
